// File: rtl/mode_control_module.sv
// Kitchen hood mode FSM: button pulses to mode code, with timed
// hurricane / exit / self-clean modes and a one-second prescaler.
module mode_control_module #(
   parameter int MODE_WIDTH   = 3,
   parameter int COUNTER_1SEC = 99_999_999,
   parameter int TIME_WIDTH   = 8,
   parameter int THIRD_SEC    = 60,
   parameter int EXIT_SEC     = 60,
   parameter int CLEAN_SEC    = 180
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  power_btn,
   input  logic                  first_btn,
   input  logic                  second_btn,
   input  logic                  third_btn,
   input  logic                  clean_btn,
   output logic [MODE_WIDTH-1:0] current_mode,
   output logic [TIME_WIDTH-1:0] remaining_sec,
   output logic                  third_used
);

   typedef enum logic [2:0] {
      S_OFF     = 3'd0,
      S_STANDBY = 3'd1,
      S_FIRST   = 3'd2,
      S_SECOND  = 3'd3,
      S_THIRD   = 3'd4,
      S_CLEAN   = 3'd5,
      S_EXIT    = 3'd6
   } state_t;

   localparam logic [TIME_WIDTH-1:0] LD_THIRD = TIME_WIDTH'(THIRD_SEC);
   localparam logic [TIME_WIDTH-1:0] LD_EXIT  = TIME_WIDTH'(EXIT_SEC);
   localparam logic [TIME_WIDTH-1:0] LD_CLEAN = TIME_WIDTH'(CLEAN_SEC);
   localparam logic [31:0]           TICK_MAX = 32'(COUNTER_1SEC);

   state_t                  state_q, state_d;
   logic [TIME_WIDTH-1:0]   rem_q, rem_d;
   logic                    used_q, used_d;
   logic [31:0]             tick_q, tick_d;
   logic                    timed;
   logic                    tick;
   logic                    expire;

   assign timed  = (state_q == S_THIRD) || (state_q == S_EXIT) ||
                   (state_q == S_CLEAN);
   assign tick   = timed && (tick_q == TICK_MAX);
   // A zero remaining count also expires so the counter cannot wrap.
   assign expire = tick && (rem_q <= TIME_WIDTH'(1));

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      used_d  = used_q;
      unique case (state_q)
         S_OFF: begin
            if (power_btn) begin
               state_d = S_STANDBY;
               used_d  = 1'b0;
            end
         end
         S_STANDBY: begin
            if (power_btn) begin
               state_d = S_OFF;
            end else if (clean_btn) begin
               state_d = S_CLEAN;
               rem_d   = LD_CLEAN;
            end else if (third_btn && !used_q) begin
               state_d = S_THIRD;
               rem_d   = LD_THIRD;
               used_d  = 1'b1;
            end else if (second_btn) begin
               state_d = S_SECOND;
            end else if (first_btn) begin
               state_d = S_FIRST;
            end
         end
         S_FIRST, S_SECOND: begin
            if (power_btn) begin
               state_d = S_STANDBY;
            end else if (third_btn && !used_q) begin
               state_d = S_THIRD;
               rem_d   = LD_THIRD;
               used_d  = 1'b1;
            end else if (second_btn) begin
               state_d = S_SECOND;
            end else if (first_btn) begin
               state_d = S_FIRST;
            end
         end
         S_THIRD: begin
            if (power_btn) begin
               state_d = S_EXIT;
               rem_d   = LD_EXIT;
            end else if (expire) begin
               state_d = S_SECOND;
               rem_d   = '0;
            end else if (tick) begin
               rem_d   = rem_q - TIME_WIDTH'(1);
            end
         end
         S_EXIT, S_CLEAN: begin
            if (power_btn) begin
               state_d = S_OFF;
               rem_d   = '0;
            end else if (expire) begin
               state_d = S_STANDBY;
               rem_d   = '0;
            end else if (tick) begin
               rem_d   = rem_q - TIME_WIDTH'(1);
            end
         end
         default: begin
            state_d = S_OFF;
            rem_d   = '0;
         end
      endcase
   end

   always_comb begin
      tick_d = tick_q + 32'd1;
      if (!timed || (state_d != state_q) || tick) begin
         tick_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_OFF;
         rem_q   <= '0;
         used_q  <= 1'b0;
         tick_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         used_q  <= used_d;
         tick_q  <= tick_d;
      end
   end

   assign current_mode  = MODE_WIDTH'(state_q);
   assign remaining_sec = rem_q;
   assign third_used    = used_q;

endmodule

// File: doc/mode_control_module.md
# mode_control_module

Central mode state machine of the kitchen exhaust hood: converts single-cycle button pulses into the `current_mode` code consumed by the per-mode event/timer modules. Owns the timed modes (hurricane third speed, exit countdown, self-clean), including their one-second prescaler and remaining-time countdown. Enforces the one-hurricane-per-power-cycle rule.

## Interface
- `MODE_WIDTH`, default 3: width of the mode code.
- `COUNTER_1SEC`, default 99_999_999: prescaler terminal value. One second lasts `COUNTER_1SEC+1` clocks.
- `TIME_WIDTH`, default 8: width of `remaining_sec`.
- `THIRD_SEC`, default 60: hurricane run length, in seconds.
- `EXIT_SEC`, default 60: extraction countdown after power-off from hurricane, in seconds.
- `CLEAN_SEC`, default 180: self-clean length, in seconds.
- `clk` in 1: the single clock.
- `rstn` in 1: reset, synchronous, active-low.
- `power_btn` in 1: one-clock pulse, already debounced and edge-detected upstream. The same applies to every `*_btn` input.
- `first_btn` in 1: select first speed.
- `second_btn` in 1: select second speed.
- `third_btn` in 1: select hurricane mode.
- `clean_btn` in 1: select self-clean.
- `current_mode` out `MODE_WIDTH`: mode code. OFF=0, STANDBY=1, FIRST=2, SECOND=3, THIRD=4, CLEAN=5, EXIT=6.
- `remaining_sec` out `TIME_WIDTH`: seconds left in THIRD, EXIT or CLEAN; 0 in every other state.
- `third_used` out 1: hurricane has been entered since the last OFF→STANDBY.

## Operation
- All outputs are registered.
- Button priority when several pulses share a cycle: power > clean > third > second > first. Only the highest-priority *legal* button acts; the others are dropped.
- Illegal buttons are ignored with no side effect.
- State transitions:
  - **OFF**: power → STANDBY and clear `third_used`. All other buttons are ignored.
  - **STANDBY**:
    - power → OFF.
    - first → FIRST; second → SECOND.
    - third → THIRD only if `third_used`=0.
    - clean → CLEAN.
  - **FIRST / SECOND**:
    - power → STANDBY.
    - first / second → the named speed; re-selecting the current speed is a no-op.
    - third → THIRD if allowed.
    - clean is ignored.
  - **THIRD**:
    - Entry sets `third_used`=1 and loads `remaining_sec`=`THIRD_SEC`.
    - Expiry → SECOND.
    - power → EXIT, loading `EXIT_SEC`.
    - first / second / third / clean are ignored.
  - **EXIT**:
    - Expiry → STANDBY.
    - power → OFF immediately (forced shutdown).
    - Other buttons are ignored.
  - **CLEAN**:
    - Entry loads `CLEAN_SEC`.
    - Expiry → STANDBY.
    - power → OFF (abort).
    - Other buttons are ignored.
- Prescaler `tick_cnt` (32 bits):
  - Counts only in THIRD, EXIT and CLEAN.
  - Increments every clock; `tick` = (`tick_cnt`==`COUNTER_1SEC`), then `tick_cnt` wraps to 0.
  - Cleared to 0 on every state change and in every untimed state.
- Countdown:
  - On `tick`, `remaining_sec` decrements.
  - On `tick` with `remaining_sec`==1, the state expires: next state is taken, and `remaining_sec` becomes the new state's load value (or 0 for an untimed state).
  - `remaining_sec` never underflows.
  - A power button in the expiry cycle wins over expiry.
- `third_used` is cleared only on the OFF→STANDBY transition and on reset. It stays set through STANDBY and the speed modes.

## Timing
- Reset (`rstn`=0 at a rising edge):
  - `current_mode`=OFF, `remaining_sec`=0, `third_used`=0.
  - `tick_cnt`=0.
  - Reset overrides everything, including a reset asserted mid-countdown.
- Latency: a button pulse sampled at edge k updates `current_mode`, `remaining_sec` and `third_used` at edge k (visible from k onward). That is one clock after the pulse is presented.
- Duration of a timed state entered at edge k: exactly N·(`COUNTER_1SEC`+1) clocks, where N is the state's load value. The next state appears at edge k+N·(`COUNTER_1SEC`+1).
- `remaining_sec` changes only on entry, on `tick`, on expiry, or on exit.
- No handshake. Buttons are not held or queued: a pulse that is dropped is lost.

## Test plan
Bench parameters: `COUNTER_1SEC`=3, `THIRD_SEC`=2, `EXIT_SEC`=2, `CLEAN_SEC`=3.

1. **Reset, power-on and speeds**
   - Stimulus: reset, then power pulse, then first pulse, then second pulse.
   - Required response: mode 0→1→2→3. `remaining_sec`=0 throughout.
2. **Hurricane expiry**
   - Stimulus: from STANDBY, pulse third.
   - Required response: mode 4, `remaining_sec`=2, `third_used`=1. `remaining_sec` reads 1 after 4 clocks. Mode 3 with `remaining_sec`=0 exactly 8 clocks after entry.
   - Stimulus: a second third pulse.
   - Required response: ignored, mode stays 3.
3. **Hurricane exit path**
   - Stimulus: enter THIRD, then power pulse 2 clocks later.
   - Required response: mode 6, `remaining_sec`=2, prescaler restarted. Mode 1 exactly 8 clocks after the power pulse.
   - Stimulus: repeat, but pulse power again during EXIT.
   - Required response: mode 0 next edge.
4. **Clean and abort**
   - Stimulus: STANDBY, pulse clean.
   - Required response: mode 5 for 12 clocks, then mode 1.
   - Stimulus: clean again, then power 5 clocks in.
   - Required response: mode 0, `remaining_sec`=0.
5. **Priority and power cycle**
   - Stimulus: in STANDBY, pulse first, second and third in the same cycle with `third_used`=0.
   - Required response: mode 4.
   - Stimulus: power in the same cycle as expiry of THIRD.
   - Required response: mode 6 (not 3).
   - Stimulus: OFF→STANDBY.
   - Required response: `third_used` clears.
6. **Mid-countdown reset**
   - Stimulus: in CLEAN with `remaining_sec`=2, hold `rstn` low for one edge.
   - Required response: mode 0, `remaining_sec`=0, `third_used`=0. A subsequent clean entry lasts the full 12 clocks.
